// File: rtl/reg_file_sb.sv
// Register file with scoreboard busy bits and a hardware clear sweep.
// Optional REG_FILE_BYPASS_EN: same-cycle write-to-read forwarding.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra_a,
  input  logic [AW-1:0]   ra_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b,
  output logic            busy_a,
  output logic            busy_b,
  input  logic            w_en,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_addr,
  input  logic            clear_req,
  output logic            ready
);

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [XLEN-1:0] r_mem [NREG];

  logic            w_run;
  logic            w_clr;
  logic            w_wr;
  logic            w_sb;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_wa;
  logic [XLEN-1:0] w_mem_wd;

  assign w_run = (r_state == ST_RUN);
  assign w_clr = w_run & clear_req;
  assign w_wr  = w_run & w_en & (wa != '0);
  assign w_sb  = w_run & sb_set & (sb_addr != '0);
  assign ready = w_run;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_SWEEP: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(NREG - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_SWEEP;
        w_cnt_nxt   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SWEEP;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A set and a retire to the same register: set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr) begin
      w_busy_nxt[wa] = 1'b0;
    end
    if (w_sb) begin
      w_busy_nxt[sb_addr] = 1'b1;
    end
    if (w_clr || !w_run) begin
      w_busy_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign w_mem_we = !w_run | w_wr;
  assign w_mem_wa = w_run ? wa : r_cnt;
  assign w_mem_wd = w_run ? wd : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_wa] <= w_mem_wd;
    end
  end

  logic w_hit_a;
  logic w_hit_b;

`ifdef REG_FILE_BYPASS_EN
  assign w_hit_a = w_wr & (wa == ra_a);
  assign w_hit_b = w_wr & (wa == ra_b);
`else
  assign w_hit_a = 1'b0;
  assign w_hit_b = 1'b0;
`endif

  always_comb begin
    rd_a   = '0;
    busy_a = 1'b0;
    if (w_run && ra_a != '0) begin
      if (w_hit_a) begin
        rd_a   = wd;
        busy_a = w_sb & (sb_addr == ra_a);
      end else begin
        rd_a   = r_mem[ra_a];
        busy_a = r_busy[ra_a];
      end
    end
  end

  always_comb begin
    rd_b   = '0;
    busy_b = 1'b0;
    if (w_run && ra_b != '0) begin
      if (w_hit_b) begin
        rd_b   = wd;
        busy_b = w_sb & (sb_addr == ra_b);
      end else begin
        rd_b   = r_mem[ra_b];
        busy_b = r_busy[ra_b];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised bench for reg_file_sb against a behavioural model.
// Honours REG_FILE_BYPASS_EN the same way as the design build.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra_a, ra_b, wa, sb_addr;
  logic [31:0] rd_a, rd_b, wd;
  logic        busy_a, busy_b;
  logic        w_en, sb_set, clear_req;
  logic        ready;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .ra_a(ra_a), .ra_b(ra_b),
    .rd_a(rd_a), .rd_b(rd_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .w_en(w_en), .wa(wa), .wd(wd),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .clear_req(clear_req), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          sweep_left;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(logic [4:0] ra);
`ifdef REG_FILE_BYPASS_EN
    return w_en && wa != 0 && wa == ra;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] ra);
    if (sweep_left > 0 || ra == 0) return 32'h0;
    if (hit(ra)) return wd;
    return m_mem[ra];
  endfunction

  function automatic logic [31:0] exp_bsy(logic [4:0] ra);
    if (sweep_left > 0 || ra == 0) return 32'h0;
    if (hit(ra)) return 32'(sb_set && sb_addr == ra);
    return 32'(m_busy[ra]);
  endfunction

  task automatic wipe();
    sweep_left = 31;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      wipe();
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      if (w_en && wa != 0) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
      if (clear_req) wipe();
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("ready", 32'(ready), 32'(sweep_left == 0));
    check("rd_a", rd_a, exp_rd(ra_a));
    check("rd_b", rd_b, exp_rd(ra_b));
    check("busy_a", 32'(busy_a), exp_bsy(ra_a));
    check("busy_b", 32'(busy_b), exp_bsy(ra_b));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    w_en = 0; sb_set = 0; clear_req = 0;
    wa = 0; wd = 0; sb_addr = 0;
  endtask

  task automatic wait_ready(string tag);
    int n = 0;
    while (!ready && n < 100) begin
      cyc();
      n++;
    end
    check(tag, 32'(n), 32'd31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: ready %b", ready);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; ra_a = 0; ra_b = 0;
    idle();
    wipe();
    #1;
    repeat (3) cyc();
    rst_n = 1;
    wait_ready("reset_lat");
    for (int i = 1; i < 32; i++) begin
      ra_a = 5'(i); ra_b = 5'(32 - i);
      cyc();
    end

    w_en = 1; wa = 5; wd = 32'hDEADBEEF;
    cyc();
    idle(); ra_a = 5; cyc();
    check("r5", rd_a, 32'hDEADBEEF);
    w_en = 1; wa = 0; wd = 32'h1234; ra_b = 0;
    cyc();
    idle(); cyc();
    check("r0", rd_b, 32'h0);

    sb_set = 1; sb_addr = 7; ra_a = 7;
    cyc();
    idle(); cyc();
    check("r7_busy", 32'(busy_a), 32'd1);
    w_en = 1; wa = 7; wd = 32'h55;
    cyc();
    idle(); cyc();
    check("r7_retire", {rd_a[30:0], busy_a}, 32'hAA);
    w_en = 1; wa = 7; wd = 32'h55;
    sb_set = 1; sb_addr = 7;
    cyc();
    idle(); cyc();
    check("r7_setwin", {rd_a[30:0], busy_a}, 32'hAB);

    w_en = 1; wa = 9; wd = 32'h11;
    cyc();
    w_en = 1; wa = 9; wd = 32'hA5A5A5A5; ra_a = 9;
    cyc();
    idle(); cyc();

    for (int i = 1; i < 32; i++) begin
      w_en = 1; wa = 5'(i); wd = 32'h100 + 32'(i);
      cyc();
    end
    idle(); sb_set = 1; sb_addr = 3;
    cyc();
    idle(); clear_req = 1;
    cyc();
    clear_req = 0;
    for (int i = 0; i < 31; i++) begin
      w_en = 1; wa = 5'(i + 1); wd = 32'hFFFF0000;
      sb_set = 1; sb_addr = 5'(i + 1);
      ra_a = 5'(i + 1); ra_b = 3;
      cyc();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      ra_a = 5'(i); ra_b = 3;
      cyc();
    end

    clear_req = 1; cyc();
    clear_req = 0;
    repeat (10) cyc();
    rst_n = 0;
    repeat (2) cyc();
    rst_n = 1;
    wait_ready("rst_mid_lat");

    for (int k = 0; k < 600; k++) begin
      w_en      = ($urandom_range(1) == 1);
      wa        = 5'($urandom_range(31));
      wd        = $urandom;
      sb_set    = ($urandom_range(2) == 0);
      sb_addr   = ($urandom_range(3) == 0) ? wa
                  : 5'($urandom_range(31));
      clear_req = ($urandom_range(60) == 0);
      ra_a      = ($urandom_range(2) == 0) ? wa
                  : 5'($urandom_range(31));
      ra_b      = ($urandom_range(3) == 0) ? ra_a
                  : 5'($urandom_range(31));
      cyc();
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
